// File: rtl/sseg_pkg.sv
// Shared constants for the seven-segment display path.
// Glyphs are gfedcba, active-high. The FSM encoding is used by the capture monitor.
package sseg_pkg;

  localparam logic [6:0] SSEG_GLYPH_0 = 7'h3F;
  localparam logic [6:0] SSEG_GLYPH_1 = 7'h06;
  localparam logic [6:0] SSEG_GLYPH_2 = 7'h5B;
  localparam logic [6:0] SSEG_GLYPH_3 = 7'h4F;
  localparam logic [6:0] SSEG_GLYPH_4 = 7'h66;
  localparam logic [6:0] SSEG_GLYPH_5 = 7'h6D;
  localparam logic [6:0] SSEG_GLYPH_6 = 7'h7D;
  localparam logic [6:0] SSEG_GLYPH_7 = 7'h07;
  localparam logic [6:0] SSEG_GLYPH_8 = 7'h7F;
  localparam logic [6:0] SSEG_GLYPH_9 = 7'h6F;
  localparam logic [6:0] SSEG_GLYPH_A = 7'h77;
  localparam logic [6:0] SSEG_GLYPH_B = 7'h7C;
  localparam logic [6:0] SSEG_GLYPH_C = 7'h39;
  localparam logic [6:0] SSEG_GLYPH_D = 7'h5E;
  localparam logic [6:0] SSEG_GLYPH_E = 7'h79;
  localparam logic [6:0] SSEG_GLYPH_F = 7'h71;
  localparam logic [6:0] SSEG_BLANK   = 7'h00;

  // BLANK: no single digit lit. SETTLE: waiting for a stable dwell. HELD: dwell captured.
  typedef enum logic [1:0] {
    ST_BLANK  = 2'd0,
    ST_SETTLE = 2'd1,
    ST_HELD   = 2'd2
  } sseg_state_e;

endpackage

// File: rtl/sseg_decode.sv
// Segment-pattern decoder: inverse of the hex-to-seven-segment encoder.
// hit_o = recognised hex glyph, blank_o = all segments off, val_o = nibble (0 if no hit).
module sseg_decode
  import sseg_pkg::*;
(
  input  logic [6:0] seg_i,
  output logic       hit_o,
  output logic       blank_o,
  output logic [3:0] val_o
);

  // Match the pattern against the 16 glyphs; everything else is a miss.
  always_comb begin
    hit_o   = 1'b1;
    blank_o = 1'b0;
    val_o   = 4'h0;
    case (seg_i)
      SSEG_GLYPH_0: val_o = 4'h0;
      SSEG_GLYPH_1: val_o = 4'h1;
      SSEG_GLYPH_2: val_o = 4'h2;
      SSEG_GLYPH_3: val_o = 4'h3;
      SSEG_GLYPH_4: val_o = 4'h4;
      SSEG_GLYPH_5: val_o = 4'h5;
      SSEG_GLYPH_6: val_o = 4'h6;
      SSEG_GLYPH_7: val_o = 4'h7;
      SSEG_GLYPH_8: val_o = 4'h8;
      SSEG_GLYPH_9: val_o = 4'h9;
      SSEG_GLYPH_A: val_o = 4'hA;
      SSEG_GLYPH_B: val_o = 4'hB;
      SSEG_GLYPH_C: val_o = 4'hC;
      SSEG_GLYPH_D: val_o = 4'hD;
      SSEG_GLYPH_E: val_o = 4'hE;
      SSEG_GLYPH_F: val_o = 4'hF;
      SSEG_BLANK: begin
        hit_o   = 1'b0;
        blank_o = 1'b1;
      end
      default: hit_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/sseg_capture.sv
// Reader end of a multiplexed seven-segment bus. Each digit is captured once
// seg/an have been stable for STABLE_CYC registered samples; frame_done pulses
// once every digit has been captured since the previous pulse.
// Optional decimal-point capture: define SSEG_CAPTURE_DP_EN.
// Bus handshake: there is none; the bus is free-running and sampled every cycle.
module sseg_capture
  import sseg_pkg::*;
#(
  parameter int N_DIG      = 4,
  parameter int STABLE_CYC = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [6:0]         seg,
  input  logic [N_DIG-1:0]   an,
`ifdef SSEG_CAPTURE_DP_EN
  input  logic               dp,
  output logic [N_DIG-1:0]   dig_dp,
`endif
  output logic [4*N_DIG-1:0] dig_out,
  output logic [N_DIG-1:0]   dig_vld,
  output logic [N_DIG-1:0]   dig_err,
  output logic               frame_done,
  output logic [1:0]         dbg_state_o
);

  localparam int CW = $clog2(STABLE_CYC + 1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYC);

  logic [6:0]         seg_q, seg_p_q;
  logic [N_DIG-1:0]   an_q, an_p_q;
  sseg_state_e        state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [N_DIG-1:0]   seen_q, seen_d, seen_new;
  logic [4*N_DIG-1:0] out_q, out_d;
  logic [N_DIG-1:0]   vld_q, vld_d, err_q, err_d;
  logic               fd_q, fd_d;
  logic               capture, bus_chg, one_hot;
  logic               dec_hit, dec_blank;
  logic [3:0]         dec_val;
`ifdef SSEG_CAPTURE_DP_EN
  logic               dp_q, dp_p_q;
  logic [N_DIG-1:0]   dpo_q, dpo_d;
`endif

  sseg_decode u_decode (
    .seg_i   (seg_q),
    .hit_o   (dec_hit),
    .blank_o (dec_blank),
    .val_o   (dec_val)
  );

  assign one_hot = $onehot(an_q);
`ifdef SSEG_CAPTURE_DP_EN
  assign bus_chg = (seg_q != seg_p_q) || (an_q != an_p_q) || (dp_q != dp_p_q);
`else
  assign bus_chg = (seg_q != seg_p_q) || (an_q != an_p_q);
`endif

  // Bus sample register plus one-deep history for change detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_q   <= '0;
      seg_p_q <= '0;
      an_q    <= '0;
      an_p_q  <= '0;
`ifdef SSEG_CAPTURE_DP_EN
      dp_q    <= 1'b0;
      dp_p_q  <= 1'b0;
`endif
    end else begin
      seg_q   <= seg;
      seg_p_q <= seg_q;
      an_q    <= an;
      an_p_q  <= an_q;
`ifdef SSEG_CAPTURE_DP_EN
      dp_q    <= dp;
      dp_p_q  <= dp_q;
`endif
    end
  end

  // Dwell FSM: restart on any bus change, capture when the count reaches STABLE_CYC.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    capture = 1'b0;
    if (!one_hot) begin
      state_d = ST_BLANK;
      cnt_d   = '0;
    end else if (state_q == ST_BLANK || bus_chg) begin
      state_d = ST_SETTLE;
      cnt_d   = CNT_ONE;
    end else if (state_q == ST_SETTLE) begin
      if (cnt_q == CNT_MAX - CNT_ONE) begin
        cnt_d   = CNT_MAX;
        state_d = ST_HELD;
        capture = 1'b1;
      end else if (cnt_q != CNT_MAX) begin
        cnt_d = cnt_q + CNT_ONE;
      end
    end
  end

  // Capture datapath: update the lit digit and track frame completion.
  always_comb begin
    out_d    = out_q;
    vld_d    = vld_q;
    err_d    = err_q;
    seen_d   = seen_q;
    fd_d     = 1'b0;
    seen_new = seen_q | an_q;
`ifdef SSEG_CAPTURE_DP_EN
    dpo_d    = dpo_q;
`endif
    if (capture) begin
      for (int i = 0; i < N_DIG; i++) begin
        if (an_q[i]) begin
          out_d[4*i +: 4] = dec_hit ? dec_val : 4'h0;
          vld_d[i]        = dec_hit;
          err_d[i]        = !dec_hit && !dec_blank;
`ifdef SSEG_CAPTURE_DP_EN
          dpo_d[i]        = dp_q;
`endif
        end
      end
      if (&seen_new) begin
        seen_d = '0;
        fd_d   = 1'b1;
      end else begin
        seen_d = seen_new;
      end
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_BLANK;
      cnt_q   <= '0;
      seen_q  <= '0;
      out_q   <= '0;
      vld_q   <= '0;
      err_q   <= '0;
      fd_q    <= 1'b0;
`ifdef SSEG_CAPTURE_DP_EN
      dpo_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      seen_q  <= seen_d;
      out_q   <= out_d;
      vld_q   <= vld_d;
      err_q   <= err_d;
      fd_q    <= fd_d;
`ifdef SSEG_CAPTURE_DP_EN
      dpo_q   <= dpo_d;
`endif
    end
  end

  assign dig_out     = out_q;
  assign dig_vld     = vld_q;
  assign dig_err     = err_q;
  assign frame_done  = fd_q;
  assign dbg_state_o = state_q;
`ifdef SSEG_CAPTURE_DP_EN
  assign dig_dp      = dpo_q;
`endif

endmodule
